data_mem_mmio: RTL
==================

// Module: data_mem_mmio
// PURPOSE
//  Data-side memory that consumes the CPU core's data_mem port (ce/we/addr/wdata) and returns load data.
//  Word RAM with combinational read: MEM stage sees rdata in the same cycle.
//  Synchronous write.
//  Also decodes a small MMIO window: TX byte FIFO with valid/ready drain, free-running cycle counter, GPIO output register.
//  Sits directly downstream of the core's MEM stage at SoC top level.
// PARAMETERS
//  RAM_AW   10  RAM word-address width; RAM holds 2**RAM_AW 32-bit words
//  FIFO_D   4   TX FIFO depth in entries; power of 2, >=2
//  GPIO_W   8   GPIO output width, <=32
// PORTS
//  clk          in   1        clock; all state updates on posedge
//  rst          in   1        synchronous, active-high reset
//  ce           in   1        access enable from core (data_ce_o)
//  we           in   1        write enable from core (data_we_o); ignored when ce=0
//  addr         in   32       byte address from core (data_addr_o)
//  wdata        in   32       store data from core (data_o)
//  rdata        out  32       load data to core (data_i); combinational
//  gpio_o       out  GPIO_W   GPIO output register
//  tx_data      out  8        FIFO head byte
//  tx_valid     out  1        FIFO non-empty
//  tx_ready     in   1        sink accepts head when tx_valid&tx_ready at posedge
// BEHAVIOUR
//  Decode:
//  - MMIO if addr[31:16]==16'hFFFF; otherwise RAM.
//  - RAM index = addr[RAM_AW+1:2]. Upper bits alias (wrap). addr[1:0] ignored; word access only.
//  MMIO map (offset addr[7:0]; unlisted offsets read 0, writes ignored):
//  - 0x00 TXDATA  W: push wdata[7:0]. R: 0.
//  - 0x04 TXSTAT  R: {24'b0, count[5:0], ovf, full}. W: wdata[1]=1 clears ovf.
//  - 0x08 CYCLE   R: counter. W: counter<=wdata (next cycle reads wdata, then +1 per cycle).
//  - 0x0C GPIO    R/W: zero-extended gpio_o; write takes wdata[GPIO_W-1:0].
//  Read path: rdata = ce&~we ? selected word : 32'h0. Pure combinational, no added latency.
//  Write path:
//  - RAM writes on posedge when ce&we.
//  - Read-during-write to the same word returns the old contents.
//  Reset values:
//  - rdata=0 (ce low).
//  - gpio_o=0, counter=0, FIFO empty, tx_valid=0, tx_data=0, ovf=0.
//  - RAM contents are not reset.
//  Cycle counter: 32-bit, +1 every cycle, wraps 0xFFFFFFFF->0. A write has priority over the increment.
//  TX FIFO (circular, rd/wr pointers + count[$clog2(FIFO_D):0]):
//  - push = ce&we&TXDATA. pop = tx_valid&tx_ready.
//  - tx_data is combinational from the head entry. Holds stable while tx_valid&~tx_ready.
//  - Push when full and no pop: data dropped, ovf<=1 (sticky), count unchanged.
//  - Push when full with simultaneous pop: accepted, count unchanged, no ovf.
//  - Push when empty: tx_valid=1 the next cycle. No same-cycle bypass.
//  - Pointers wrap modulo FIFO_D.
//  - Status write setting bit1 while an overflowing push occurs in the same cycle is impossible (single port).
//  - ovf clear and a later overflow follow program order.
//  Reset mid-operation:
//  - FIFO flushed; pending tx_valid drops next cycle regardless of tx_ready.
//  - Any in-flight write in the reset cycle is discarded.
// STRUCTURE
//  Shared package/header:
//  - MMIO base 16'hFFFF.
//  - Offset constants TXDATA/TXSTAT/CYCLE/GPIO.
//  - TXSTAT bit positions.
//  Sub-module mmio_tx_fifo:
//  - Parameters: FIFO_D, width 8.
//  - Signals: push/din/pop, count/full/empty/ovf/ovf_clr.
//  - Owns pointers and the sticky overflow flag.
//  Top:
//  - RAM array.
//  - Address decode.
//  - Read mux.
//  - Counter and GPIO registers.
// TESTING
//  RAM: write 0x1234_5678 @0x0000_0040, then read @0x40 -> rdata=0x1234_5678 same cycle.
//    Read @(0x40 + 4*2**RAM_AW) -> same value (alias).
//  Reset: hold rst 1 cycle after activity -> gpio_o=0, tx_valid=0, TXSTAT reads 0, CYCLE reads 0 then 1,2,3 on following cycles.
//  FIFO: tx_ready=0, push 0x41..0x45 (FIFO_D=4).
//    -> TXSTAT=0x13 (count4, ovf, full).
//    Then tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid=0.
//  Full push+pop: FIFO full, tx_ready=1, push 0x55 same cycle -> count stays 4, ovf stays 0, 0x55 drains last.
//  Counter: write CYCLE=0xFFFF_FFFE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on successive cycles.
//  GPIO: write 0xFFFF_FFA5 to GPIO -> gpio_o=0xA5 next cycle, read returns 0x0000_00A5.
//    Write TXSTAT bit1 -> ovf clears.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the data memory / MMIO block: window base, register
// offsets, TXSTAT field positions and the address-decode helper.
package data_mem_mmio_pkg;

   localparam logic [15:0] MMIO_BASE  = 16'hFFFF;

   localparam logic [7:0]  OFF_TXDATA = 8'h00;
   localparam logic [7:0]  OFF_TXSTAT = 8'h04;
   localparam logic [7:0]  OFF_CYCLE  = 8'h08;
   localparam logic [7:0]  OFF_GPIO   = 8'h0C;

   localparam int TXSTAT_FULL_BIT = 0;
   localparam int TXSTAT_OVF_BIT  = 1;
   localparam int TXSTAT_CNT_LSB  = 2;
   localparam int TXSTAT_CNT_W    = 6;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_TXDATA,
      SEL_TXSTAT,
      SEL_CYCLE,
      SEL_GPIO,
      SEL_NONE
   } sel_e;

   // Anything outside the MMIO window is RAM; inside it only the low offset byte matters.
   function automatic sel_e decodeSel(input logic [15:0] hi, input logic [7:0] off);
      sel_e sel;
      if (hi != MMIO_BASE) begin
         sel = SEL_RAM;
      end else begin
         case (off)
            OFF_TXDATA: sel = SEL_TXDATA;
            OFF_TXSTAT: sel = SEL_TXSTAT;
            OFF_CYCLE:  sel = SEL_CYCLE;
            OFF_GPIO:   sel = SEL_GPIO;
            default:    sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// Circular TX byte FIFO with a sticky overflow flag; a push into a full FIFO
// is only accepted when a pop happens in the same cycle.
module mmio_tx_fifo #(
   parameter int FIFO_D = 4,
   parameter int WIDTH  = 8,
   localparam int AW    = $clog2(FIFO_D),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   input  logic             i_ovfClr,
   output logic [WIDTH-1:0] o_dout,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_ovf
);

   logic [WIDTH-1:0] r_mem [FIFO_D];
   logic [AW-1:0]    r_rdPtr;
   logic [AW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;

   logic w_full;
   logic w_empty;
   logic w_doPop;
   logic w_doPush;
   logic w_drop;

   assign w_full   = (r_count == CW'(FIFO_D));
   assign w_empty  = (r_count == '0);
   assign w_doPop  = i_pop & ~w_empty;
   assign w_doPush = i_push & (~w_full | w_doPop);
   assign w_drop   = i_push & w_full & ~w_doPop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_din;
            r_wrPtr        <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // An overflow in the same cycle as a clear keeps the flag set.
         if (w_drop) begin
            r_ovf <= 1'b1;
         end else if (i_ovfClr) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign o_dout  = w_empty ? '0 : r_mem[r_rdPtr];
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory for the core's MEM stage: word RAM with combinational read,
// plus an MMIO window holding the TX FIFO, a cycle counter and a GPIO register.
module data_mem_mmio
   import data_mem_mmio_pkg::*;
#(
   parameter int RAM_AW = 10,
   parameter int FIFO_D = 4,
   parameter int GPIO_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int CW = $clog2(FIFO_D) + 1;

   logic [31:0]       r_ram [2**RAM_AW];
   logic [31:0]       r_cycle;
   logic [GPIO_W-1:0] r_gpio;

   sel_e              w_sel;
   logic              w_wr;
   logic              w_rd;
   logic [RAM_AW-1:0] w_ramIdx;
   logic [31:0]       w_rdata;
   logic [31:0]       w_txStat;
   logic              w_push;
   logic              w_pop;
   logic              w_ovfClr;
   logic [CW-1:0]     w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_ovf;
   logic              w_unusedAddr;

   assign w_sel    = decodeSel(addr[31:16], addr[7:0]);
   assign w_ramIdx = addr[RAM_AW+1:2];
   assign w_rd     = ce & ~we;
   // Writes presented during reset are dropped everywhere, including the RAM.
   assign w_wr     = ce & we & ~rst;

   assign w_unusedAddr = ^addr;

   assign w_push   = w_wr & (w_sel == SEL_TXDATA);
   assign w_pop    = tx_valid & tx_ready;
   assign w_ovfClr = w_wr & (w_sel == SEL_TXSTAT) & wdata[TXSTAT_OVF_BIT];

   mmio_tx_fifo #(
      .FIFO_D (FIFO_D),
      .WIDTH  (8)
   ) u_txFifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_push),
      .i_din    (wdata[7:0]),
      .i_pop    (w_pop),
      .i_ovfClr (w_ovfClr),
      .o_dout   (tx_data),
      .o_count  (w_count),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_ovf    (w_ovf)
   );

   assign tx_valid = ~w_empty;

   // Combinational read sees the pre-write contents during a same-word write.
   always_ff @(posedge clk) begin
      if (w_wr && (w_sel == SEL_RAM)) begin
         r_ram[w_ramIdx] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle <= '0;
      end else if (w_wr && (w_sel == SEL_CYCLE)) begin
         r_cycle <= wdata;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gpio <= '0;
      end else if (w_wr && (w_sel == SEL_GPIO)) begin
         r_gpio <= wdata[GPIO_W-1:0];
      end
   end

   assign gpio_o = r_gpio;

   always_comb begin
      w_txStat = '0;
      w_txStat[TXSTAT_FULL_BIT] = w_full;
      w_txStat[TXSTAT_OVF_BIT]  = w_ovf;
      w_txStat[TXSTAT_CNT_LSB +: TXSTAT_CNT_W] = TXSTAT_CNT_W'(w_count);
   end

   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         case (w_sel)
            SEL_RAM:    w_rdata = r_ram[w_ramIdx];
            SEL_TXSTAT: w_rdata = w_txStat;
            SEL_CYCLE:  w_rdata = r_cycle;
            SEL_GPIO:   w_rdata = 32'(r_gpio);
            default:    w_rdata = '0;
         endcase
      end
   end

   assign rdata = w_rdata;

endmodule
